// File: rtl/servo_target_slew_limiter_pkg.sv
// servo_pkg: shared axis width, FSM encoding and abs helper for the servo slew limiter
package servo_pkg;
   localparam int AXIS_W = 10;
   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   function automatic int abs_s(input int v);
      return v < 0 ? -v : v;
   endfunction
endpackage

// File: rtl/servo_target_slew_limiter_slew_axis.sv
// slew_axis: one axis target register, deadband/step rule and post-update in-band flag
module slew_axis
   import servo_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_W,
   parameter int MAX_STEP   = 8,
   parameter int DEADBAND   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample,
   input  logic                  upd,
   input  logic [DATA_WIDTH-1:0] tgt_in,
   output logic [DATA_WIDTH-1:0] out_v,
   output logic                  in_band
);
   localparam int W = DATA_WIDTH;
   localparam logic signed [W:0] MS = (W+1)'(MAX_STEP);
   logic [W-1:0] target_q, target_d, out_q, out_d;
   logic signed [W:0] d, d_post, step;
   int ad;
   // the update uses the previously sampled target; the fresh sample only feeds settled
   always_comb begin
      target_d = sample ? tgt_in : target_q;
      d        = $signed({target_q[W-1], target_q}) - $signed({out_q[W-1], out_q});
      ad       = abs_s(int'(d));
      step     = d < 0 ? -MS : MS;
      out_d    = (!upd || ad <= DEADBAND) ? out_q : ad <= MAX_STEP ? target_q : out_q + step[W-1:0];
      d_post   = $signed({target_d[W-1], target_d}) - $signed({out_d[W-1], out_d});
      in_band  = abs_s(int'(d_post)) <= DEADBAND;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target_q <= '0;
         out_q    <= '0;
      end else begin
         target_q <= target_d;
         out_q    <= out_d;
      end
   end
   assign out_v = out_q;
endmodule

// File: rtl/servo_target_slew_limiter.sv
// servo_target_slew_limiter: tick generator, INIT/RUN/HOLD control and settled flag
// over three slew-limited servo axes.
module servo_target_slew_limiter
   import servo_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_W,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int UPDATE_HZ  = 100,
   parameter int MAX_STEP   = 8,
   parameter int DEADBAND   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic [DATA_WIDTH-1:0] y_in,
   input  logic [DATA_WIDTH-1:0] z_in,
   input  logic                  hold,
   output logic [DATA_WIDTH-1:0] x_out,
   output logic [DATA_WIDTH-1:0] y_out,
   output logic [DATA_WIDTH-1:0] z_out,
   output logic                  tick,
   output logic                  settled
);
   localparam int TICK_DIV = CLK_FREQ / UPDATE_HZ;
   localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] state_q, state_d;
   logic settled_q, settled_d, upd;
   logic [2:0] band;
   always_comb begin
      tick      = cnt_q == CW'(TICK_DIV - 1);
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      upd       = tick && !hold && state_q != S_INIT;
      state_d   = !tick ? state_q : state_q == S_INIT ? S_RUN : hold ? S_HOLD : S_RUN;
      settled_d = tick ? upd && &band : settled_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         state_q   <= S_INIT;
         settled_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         settled_q <= settled_d;
      end
   end
   assign settled = settled_q;
   slew_axis #(.DATA_WIDTH(DATA_WIDTH), .MAX_STEP(MAX_STEP), .DEADBAND(DEADBAND)) u_x (
      .clk(clk), .rst(rst), .sample(tick), .upd(upd), .tgt_in(x_in), .out_v(x_out), .in_band(band[0]));
   slew_axis #(.DATA_WIDTH(DATA_WIDTH), .MAX_STEP(MAX_STEP), .DEADBAND(DEADBAND)) u_y (
      .clk(clk), .rst(rst), .sample(tick), .upd(upd), .tgt_in(y_in), .out_v(y_out), .in_band(band[1]));
   slew_axis #(.DATA_WIDTH(DATA_WIDTH), .MAX_STEP(MAX_STEP), .DEADBAND(DEADBAND)) u_z (
      .clk(clk), .rst(rst), .sample(tick), .upd(upd), .tgt_in(z_in), .out_v(z_out), .in_band(band[2]));
endmodule

// File: doc/servo_target_slew_limiter.md
Name: servo_target_slew_limiter

Overview:
Per-axis slew-rate limiter and deadband filter on the selected X/Y/Z targets. It sits between the memory/accelerometer source multiplexer and pwm_servos. It turns abrupt target jumps (source switch, ROM step, accelerometer noise) into bounded ramps so the servos never see a full-range step. Outputs feed pwm_servos x/y/z directly; settled can drive a LED.

Parameters:
DATA_WIDTH, 10, width of each signed two's-complement axis value
CLK_FREQ, 50_000_000, clk frequency in Hz
UPDATE_HZ, 100, output update rate in Hz; tick period TICK_DIV = CLK_FREQ/UPDATE_HZ cycles
MAX_STEP, 8, maximum change per axis per tick (LSB), 1..2^(DATA_WIDTH-1)-1
DEADBAND, 2, |target-output| <= DEADBAND is treated as no motion

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
x_in  input  DATA_WIDTH  signed X target from source mux
y_in  input  DATA_WIDTH  signed Y target
z_in  input  DATA_WIDTH  signed Z target
hold  input  1  level; 1 freezes outputs at current value
x_out  output  DATA_WIDTH  signed limited X
y_out  output  DATA_WIDTH  signed limited Y
z_out  output  DATA_WIDTH  signed limited Z
tick  output  1  one-cycle pulse on each update instant
settled  output  1  1 when all three axes are within DEADBAND of their sampled target

Behaviour:
- Reset (rst=0, async): x/y/z_out=0 (servo centre), tick=0, settled=0, tick counter=0, FSM=INIT.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle when the counter equals TICK_DIV-1. The counter runs in every state, including during hold.
- Sampling: x/y/z_in are captured into target registers only on tick cycles. Input changes between ticks are ignored.
- FSM states:
  - INIT: on first tick, capture targets and go to RUN. Outputs stay 0 and are not snapped; they ramp from 0.
  - RUN: on each tick, capture targets and update each axis. If hold=1 at a tick, go to HOLD and make no update.
  - HOLD: outputs frozen, targets still captured on each tick, settled forced to 0. At the first tick with hold=0, return to RUN and perform the normal update in that same tick.
- Per-axis update (on tick, RUN), with sign-extended DATA_WIDTH+1 arithmetic and d = target - out:
  - |d| <= DEADBAND: out unchanged.
  - DEADBAND < |d| <= MAX_STEP: out = target.
  - |d| > MAX_STEP: out = out + sign(d)*MAX_STEP.
  - No overflow is possible because the result always lies between out and target. The most-negative input (-512) is legal.
- Latency: an input change appears on the output at the second tick edge after it is applied, no later than 2*TICK_DIV cycles plus 1. Outputs change only in the cycle after tick.
- settled: registered, updated with the outputs. It is 1 iff in RUN and all three post-update |target-out| <= DEADBAND. Computed with the same d logic.
- hold toggling between ticks: only its value at the tick cycle matters.
- Reset mid-ramp: outputs return to 0 immediately (async), then ramp again from INIT.
- If DEADBAND >= MAX_STEP, the "out = target" branch never occurs. This is legal; the output stops within DEADBAND of target.

Decomposition:
- Package servo_pkg holds:
  - AXIS_W=10
  - FSM state encoding (INIT, RUN, HOLD)
  - a signed-abs function for DATA_WIDTH+1 values
- Sub-module slew_axis holds the per-axis target register, d/abs computation, step rule and in-band flag. It is instantiated three times.
- Top level holds the tick counter, the FSM and the settled AND.

Test Plan:
(Bench parameters: CLK_FREQ=100, UPDATE_HZ=10 -> TICK_DIV=10, MAX_STEP=8, DEADBAND=2)
- Reset, x_in=y_in=z_in=0 -> outputs 0, tick every 10 cycles, settled=1 after second tick.
- x_in=40 from settled 0 -> x_out 8,16,24,32,40 on successive ticks; settled=0 until x_out=40, then 1.
- x_in=-512 from x_out=40 -> decrements by 8 per tick, reaches -512 exactly after 69 ticks with no wrap; y/z unchanged.
- Settled at 100, x_in=102 then 98 -> x_out stays 100 (deadband). x_in=105 -> x_out=105 in one tick.
- Ramp to 200 under way, hold=1 at x_out=48 -> output frozen 48 and settled=0 across 5 ticks. Release -> next tick 56.
- rst pulsed low mid-ramp at x_out=64 -> x_out=0 asynchronously, tick counter 0, ramp restarts after INIT tick.
